// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : Valid/ready pipeline stage register with flush. SKID=1 gives |
// |               a 2-entry stage with a registered in_ready. SKID=0 gives a   |
// |               1-entry stage whose in_ready passes out_ready through.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
    parameter int unsigned      WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // The state encoding equals the number of held entries, so it
    // drives occupancy directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    generate
        if (SKID) begin : g_skid
            state_t           r_state;
            state_t           w_state_nxt;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic             r_in_ready;
            logic             w_out_valid;
            logic             w_accept;
            logic             w_consume;
            logic             w_load_main_in;
            logic             w_load_main_skid;
            logic             w_load_skid;

            assign w_out_valid = (r_state != ST_EMPTY);

            // Flush masks both handshakes so a squashed edge moves no data.
            always_comb begin
                w_accept  = in_valid & r_in_ready & ~flush;
                w_consume = w_out_valid & out_ready & ~flush;
            end

            // Next-state and datapath load selects; flush always wins.
            always_comb begin
                w_state_nxt      = r_state;
                w_load_main_in   = 1'b0;
                w_load_main_skid = 1'b0;
                w_load_skid      = 1'b0;
                if (flush) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                w_state_nxt    = ST_MAIN;
                                w_load_main_in = 1'b1;
                            end
                        end
                        ST_MAIN: begin
                            if (w_accept && w_consume) begin
                                w_load_main_in = 1'b1;
                            end else if (w_accept) begin
                                w_state_nxt = ST_FULL;
                                w_load_skid = 1'b1;
                            end else if (w_consume) begin
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // in_ready is low here, so only a consume can occur.
                            if (w_consume) begin
                                w_state_nxt      = ST_MAIN;
                                w_load_main_skid = 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_EMPTY;
                        end
                    endcase
                end
            end

            // State register; in_ready is registered from the next state, and
            // stays low through reset so the release edge cannot accept.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            // Payload registers: head takes new data or the skid entry.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_main <= BUBBLE;
                    r_skid <= BUBBLE;
                end else begin
                    if (w_load_main_in) begin
                        r_main <= in_data;
                    end else if (w_load_main_skid) begin
                        r_main <= r_skid;
                    end
                    if (w_load_skid) begin
                        r_skid <= in_data;
                    end
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = w_out_valid;
            assign out_data  = w_out_valid ? r_main : BUBBLE;
            assign occupancy = r_state;
        end else begin : g_pass
            logic             r_valid;
            logic [WIDTH-1:0] r_main;
            logic             w_in_ready;
            logic             w_accept;
            logic             w_consume;

            // Single entry: room exists when empty or when the head leaves now.
            always_comb begin
                w_in_ready = ~r_valid | out_ready;
                w_accept   = in_valid & w_in_ready & ~flush;
                w_consume  = r_valid & out_ready & ~flush;
            end

            // Valid flag; an accept on a consume edge keeps the entry live.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                end else if (w_consume) begin
                    r_valid <= 1'b0;
                end
            end

            // Head payload, replaced on every accept.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_main <= BUBBLE;
                end else if (w_accept) begin
                    r_main <= in_data;
                end
            end

            assign in_ready  = w_in_ready;
            assign out_valid = r_valid;
            assign out_data  = r_valid ? r_main : BUBBLE;
            assign occupancy = {1'b0, r_valid};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                            |
// | Description : Bench for pipe_stage_reg: a SKID=1/WIDTH=64 instance and a   |
// |               SKID=0/WIDTH=32 instance checked against queue models.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;

    localparam logic [63:0] c_bubble1 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [31:0] c_bubble0 = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;

    logic        in_valid1, in_ready1, flush1, out_valid1, out_ready1;
    logic [63:0] in_data1, out_data1;
    logic [1:0]  occ1;

    logic        in_valid0, in_ready0, flush0, out_valid0, out_ready0;
    logic [31:0] in_data0, out_data0;
    logic [1:0]  occ0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference models: FIFO contents in acceptance order.
    logic [63:0] q1[$];
    logic [31:0] q0[$];
    bit          m_rdy1;

    pipe_stage_reg #(.WIDTH(64), .BUBBLE(c_bubble1), .SKID(1'b1)) u_dut_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .flush(flush1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.WIDTH(32), .BUBBLE(c_bubble0), .SKID(1'b0)) u_dut_pass (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .flush(flush0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        m_rdy1 = 1'b0;
    endtask

    task automatic compare_all();
        check("skid_valid", {63'd0, out_valid1}, {63'd0, q1.size() > 0});
        check("skid_data", out_data1, (q1.size() > 0) ? q1[0] : c_bubble1);
        check("skid_occ", {62'd0, occ1}, 64'(q1.size()));
        check("skid_in_ready", {63'd0, in_ready1}, {63'd0, m_rdy1});
        check("skid_occ_max", {63'd0, occ1 <= 2'd2}, 64'd1);
        check("pass_valid", {63'd0, out_valid0}, {63'd0, q0.size() > 0});
        check("pass_data", {32'd0, out_data0}, {32'd0, (q0.size() > 0) ? q0[0] : c_bubble0});
        check("pass_occ", {62'd0, occ0}, 64'(q0.size()));
        check("pass_in_ready", {63'd0, in_ready0}, {63'd0, (q0.size() == 0) || out_ready0});
    endtask

    // Called at a negedge with inputs set: check, cross one rising edge, update models.
    task automatic cycle();
        bit acc1, cons1, acc0, cons0;
        #1 compare_all();
        acc1  = in_valid1 && m_rdy1 && !flush1;
        cons1 = (q1.size() > 0) && out_ready1 && !flush1;
        acc0  = in_valid0 && ((q0.size() == 0) || out_ready0) && !flush0;
        cons0 = (q0.size() > 0) && out_ready0 && !flush0;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (flush1) q1.delete();
            else begin
                if (cons1) void'(q1.pop_front());
                if (acc1)  q1.push_back(in_data1);
            end
            m_rdy1 = (q1.size() < 2);
            if (flush0) q0.delete();
            else begin
                if (cons0) void'(q0.pop_front());
                if (acc0)  q0.push_back(in_data0);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid1 = 0; in_data1 = '0; flush1 = 0; out_ready1 = 0;
        in_valid0 = 0; in_data0 = '0; flush0 = 0; out_ready0 = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        // Reset state
        #1 compare_all();
        check("rst_skid_in_ready", {63'd0, in_ready1}, 64'd0);
        check("rst_pass_in_ready", {63'd0, in_ready0}, 64'd1);
        check("rst_skid_data", out_data1, c_bubble1);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        check("release_in_ready", {63'd0, in_ready1}, 64'd1);

        // Streaming through the skid stage
        out_ready1 = 1;
        for (int k = 1; k <= 8; k++) begin
            in_valid1 = 1; in_data1 = 64'(k);
            cycle();
            check("stream_data", out_data1, 64'(k));
            check("stream_occ", {62'd0, occ1}, 64'd1);
        end
        in_valid1 = 0;
        cycle();
        check("stream_drain", {63'd0, out_valid1}, 64'd0);

        // Backpressure fill and in-order drain
        out_ready1 = 0;
        in_valid1 = 1; in_data1 = 64'hA; cycle();
        in_data1 = 64'hB; cycle();
        in_valid1 = 0;
        check("bp_occ_full", {62'd0, occ1}, 64'd2);
        check("bp_in_ready_low", {63'd0, in_ready1}, 64'd0);
        check("bp_head_a", out_data1, 64'hA);
        out_ready1 = 1; cycle();
        check("bp_head_b", out_data1, 64'hB);
        check("bp_in_ready_back", {63'd0, in_ready1}, 64'd1);
        cycle();
        check("bp_empty", {63'd0, out_valid1}, 64'd0);

        // Flush colliding with accept and consume while full
        out_ready1 = 0;
        in_valid1 = 1; in_data1 = 64'hA; cycle();
        in_data1 = 64'hB; cycle();
        in_data1 = 64'hC; flush1 = 1; out_ready1 = 1; cycle();
        check("flush_valid", {63'd0, out_valid1}, 64'd0);
        check("flush_data", out_data1, c_bubble1);
        check("flush_occ", {62'd0, occ1}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready1}, 64'd1);
        flush1 = 0; in_valid1 = 0;
        repeat (3) cycle();
        check("flush_no_c", {63'd0, out_valid1}, 64'd0);

        // Asynchronous reset while full
        out_ready1 = 0;
        in_valid1 = 1; in_data1 = 64'h11; cycle();
        in_data1 = 64'h22; cycle();
        check("arst_pre_occ", {62'd0, occ1}, 64'd2);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst_valid", {63'd0, out_valid1}, 64'd0);
        check("arst_occ", {62'd0, occ1}, 64'd0);
        check("arst_data", out_data1, c_bubble1);
        check("arst_in_ready", {63'd0, in_ready1}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid1 = 1; in_data1 = 64'h77;
        cycle();
        check("arst_rel_in_ready", {63'd0, in_ready1}, 64'd1);
        check("arst_rel_no_accept", {62'd0, occ1}, 64'd0);
        in_valid1 = 0;
        cycle();

        // Pass-ready mode: combinational in_ready and same-edge replace
        in_valid0 = 1; in_data0 = 32'h5; out_ready0 = 0; cycle();
        in_valid0 = 0; cycle();
        check("pass_hold_data", {32'd0, out_data0}, 64'h5);
        check("pass_in_ready_low", {63'd0, in_ready0}, 64'd0);
        in_valid0 = 1; in_data0 = 32'h6; out_ready0 = 1;
        #1 check("pass_in_ready_comb", {63'd0, in_ready0}, 64'd1);
        cycle();
        check("pass_replace", {32'd0, out_data0}, 64'h6);
        check("pass_occ_one", {62'd0, occ0}, 64'd1);
        in_valid0 = 0; cycle();
        check("pass_empty", {63'd0, out_valid0}, 64'd0);

        // Randomised valid/ready/flush run on both instances
        for (int c = 0; c < 10000; c++) begin
            in_valid1  = ($urandom_range(0, 99) < 60);
            in_data1   = {$urandom, $urandom};
            out_ready1 = ($urandom_range(0, 99) < 50);
            flush1     = ($urandom_range(0, 63) == 0);
            in_valid0  = ($urandom_range(0, 99) < 60);
            in_data0   = $urandom;
            out_ready0 = ($urandom_range(0, 99) < 50);
            flush0     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning payload width in bits (PC+4 concatenated with instruction).
REQ-002 The block SHALL have parameter BUBBLE, default 0 (WIDTH bits), meaning the payload value driven on out_data whenever out_valid is 0.
REQ-003 The block SHALL have parameter SKID, default 1, meaning 1 selects the 2-entry registered-ready skid mode and 0 selects the 1-entry pass-ready mode.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning the reset: asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the upstream stage presents a payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the stage accepts the payload this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits, meaning the upstream payload.
REQ-009 The block SHALL have port flush, input, 1 bit, meaning discard all held entries (branch/jump squash).
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a live payload.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the downstream stage consumes the payload this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH bits, meaning the head payload.
REQ-013 The block SHALL have port occupancy, output, 2 bits, meaning the number of held entries (0..2).

Function
REQ-014 The block SHALL accept a payload on a rising edge with in_valid=1, in_ready=1, flush=0, and complete a transfer out on a rising edge with out_valid=1, out_ready=1, flush=0.
REQ-015 The block SHALL have a minimum latency of 1 cycle: data accepted at edge N appears on out_data with out_valid=1 after edge N when the stage was empty.
REQ-016 The block SHALL deliver payloads in strict acceptance order, with none duplicated or dropped except by flush.
REQ-017 The block SHALL drive out_data to BUBBLE whenever out_valid=0.
REQ-018 In SKID=1 mode, the block SHALL implement states EMPTY (occ 0), MAIN (occ 1) and FULL (occ 2, main+skid).
REQ-019 In SKID=1 mode, in_ready SHALL be a register output equal to (state != FULL), with no combinational path from out_ready.
REQ-020 The EMPTY state SHALL go to MAIN on accept and otherwise stay EMPTY.
REQ-021 The MAIN state SHALL stay MAIN on accept+consume; go to FULL on accept without consume, with the new payload held in skid; go to EMPTY on consume without accept; and otherwise hold.
REQ-022 The FULL state SHALL go to MAIN on consume, with the skid payload moving to the head on the same edge; otherwise it SHALL hold; no accept is possible in FULL.
REQ-023 In SKID=0 mode, the block SHALL use a single entry with in_ready = !out_valid || out_ready (combinational); accept+consume on the same edge replaces the head; occupancy never exceeds 1.
REQ-024 Flush SHALL take priority over all events: on an edge with flush=1, every entry is invalidated, state becomes EMPTY, occupancy becomes 0, and any simultaneous in_valid/out_ready handshake is ignored (not accepted, not consumed).
REQ-025 In SKID=1 mode, in the cycle after a flush in_ready SHALL be 1.
REQ-026 The block SHALL not modify payload bits; in_data SHALL be captured verbatim for any WIDTH >= 1.

Reset
REQ-027 While rst=0, asynchronously and regardless of clk, the block SHALL force out_valid=0, out_data=BUBBLE, occupancy=0, state EMPTY, and skid entry invalid.
REQ-028 While rst=0, in_ready SHALL be 0 in SKID=1 mode and 1 in SKID=0 mode.
REQ-029 On the first rising edge after rst returns to 1, the block SHALL present in_ready=1 in both modes and SHALL NOT accept data on the rst-release edge.
REQ-030 Assertion of rst mid-transfer SHALL discard all held payloads immediately, without waiting for an edge.

Verification
REQ-031 Bench SHALL cover streaming: SKID=1, out_ready=1, in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 each one cycle later, occupancy stays 1, no gaps.
REQ-032 Bench SHALL cover backpressure: load 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 next cycle; raise out_ready -> 0xA then 0xB emitted in order, in_ready returns 1 after the first consume.
REQ-033 Bench SHALL cover flush collision: FULL with 0xA/0xB, assert flush with in_valid=1 (0xC) and out_ready=1 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, 0xC never appears.
REQ-034 Bench SHALL cover async reset: drop rst mid-cycle while occupancy=2 -> out_valid=0 and occupancy=0 before the next clk edge; release -> in_ready=1 after the first edge.
REQ-035 Bench SHALL cover SKID=0 with WIDTH=32: hold out_ready=0 with 0x5 held -> in_ready=0 combinationally; pulse out_ready with in_valid=1 (0x6) -> 0x6 replaces 0x5 on the same edge.
REQ-036 Bench SHALL cover randomised valid/ready run of 10,000 cycles with a scoreboard -> order preserved, zero loss or duplication, occupancy never above 2.
